sdram_req_sched: RTL and testbench

Request scheduler between the write/read FIFOs and `sdram_control`. It watches FIFO fill levels and arbitrates round-robin between write and read bursts. It holds a command until the controller accepts it, latches a stable bank/row/column address for each burst, and advances wrapping write and read pointers by one burst on each completion.

---
 rtl/sdram_req_sched.sv | 121 ++++++++++++
 tb/tb_sdram_req_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_sched.sv
// sdram_req_sched: issues write/read burst commands to the SDRAM controller.
// Watches FIFO fill levels, arbitrates round-robin between write and read
// bursts, holds the command until acknowledged, latches the burst address on
// the grant edge and advances wrapping write/read pointers on completion.
module sdram_req_sched #(
  parameter int SC_BL    = 8,
  parameter int RD_LIMIT = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] wr_addr_i,
  input  logic [23:0] wr_max_addr_i,
  input  logic [23:0] rd_addr_i,
  input  logic [23:0] rd_max_addr_i,
  input  logic        wr_load_i,
  input  logic        rd_load_i,
  input  logic [7:0]  wr_fifo_use_i,
  input  logic [7:0]  rd_fifo_use_i,
  input  logic        cmd_ack_i,
  input  logic        wdata_done_i,
  input  logic        rdata_done_i,
  output logic        wr_o,
  output logic        rd_o,
  output logic [1:0]  baddr_o,
  output logic [12:0] raddr_o,
  output logic [8:0]  caddr_o,
  output logic        busy_o
);

  localparam logic [23:0] BL24  = 24'(SC_BL);
  localparam logic [8:0]  BL9   = 9'(SC_BL);
  localparam logic [8:0]  LIM9  = 9'(RD_LIMIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_BUSY = 3'd2,
    RD_REQ  = 3'd3,
    RD_BUSY = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        last_rd_q, last_rd_d;   // 1: most recent grant was a read
  logic [23:0] addr_q, addr_d;         // address of the current burst
  logic [23:0] wr_ptr_q, wr_ptr_d;
  logic [23:0] rd_ptr_q, rd_ptr_d;

  logic wr_pend;
  logic rd_pend;

  // A load blocks grants of its own type; the pointer is being re-based.
  assign wr_pend = ({1'b0, wr_fifo_use_i} >= BL9)  && !wr_load_i;
  assign rd_pend = ({1'b0, rd_fifo_use_i} <  LIM9) && !rd_load_i;

  // Next-state, grant arbitration, address latch and pointer update.
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    addr_d    = addr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    unique case (state_q)
      IDLE: begin
        // On contention the type not granted last wins.
        if (wr_pend && (!rd_pend || last_rd_q)) begin
          state_d   = WR_REQ;
          last_rd_d = 1'b0;
          addr_d    = wr_ptr_q;
        end else if (rd_pend) begin
          state_d   = RD_REQ;
          last_rd_d = 1'b1;
          addr_d    = rd_ptr_q;
        end
      end
      // Done pulses in REQ are ignored; only the acknowledge counts.
      WR_REQ:  if (cmd_ack_i) state_d = WR_BUSY;
      RD_REQ:  if (cmd_ack_i) state_d = RD_BUSY;
      WR_BUSY: begin
        if (wdata_done_i) begin
          state_d  = IDLE;
          wr_ptr_d = (wr_ptr_q == wr_max_addr_i - BL24) ? wr_addr_i : wr_ptr_q + BL24;
        end
      end
      RD_BUSY: begin
        if (rdata_done_i) begin
          state_d  = IDLE;
          rd_ptr_d = (rd_ptr_q == rd_max_addr_i - BL24) ? rd_addr_i : rd_ptr_q + BL24;
        end
      end
      default: state_d = IDLE;
    endcase
    // Load wins over any same-cycle advance.
    if (wr_load_i) wr_ptr_d = wr_addr_i;
    if (rd_load_i) rd_ptr_d = rd_addr_i;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      addr_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      addr_q    <= addr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign wr_o    = (state_q == WR_REQ);
  assign rd_o    = (state_q == RD_REQ);
  assign busy_o  = (state_q != IDLE);
  assign baddr_o = addr_q[23:22];
  assign raddr_o = addr_q[21:9];
  assign caddr_o = addr_q[8:0];

endmodule

// File: tb/tb_sdram_req_sched.sv
// tb_sdram_req_sched: directed steps followed by a randomized run, every cycle
// checked against a transaction-level model of the scheduler.
module tb_sdram_req_sched;

  localparam int BL  = 8;
  localparam int LIM = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] wr_addr, wr_max_addr, rd_addr, rd_max_addr;
  logic        wr_load, rd_load;
  logic [7:0]  wr_use, rd_use;
  logic        ack, wdone, rdone;
  logic        wr_o, rd_o, busy_o;
  logic [1:0]  baddr_o;
  logic [12:0] raddr_o;
  logic [8:0]  caddr_o;

  int ncmp  = 0;
  int nfail = 0;

  // Model: phase 0 = no command, 1 = command requested, 2 = burst running.
  int          m_phase;
  int          m_kind;      // 0 write, 1 read
  logic [23:0] m_addr, m_wptr, m_rptr;
  bit          m_last_rd;

  sdram_req_sched #(.SC_BL(BL), .RD_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_addr_i(wr_addr), .wr_max_addr_i(wr_max_addr),
    .rd_addr_i(rd_addr), .rd_max_addr_i(rd_max_addr),
    .wr_load_i(wr_load), .rd_load_i(rd_load),
    .wr_fifo_use_i(wr_use), .rd_fifo_use_i(rd_use),
    .cmd_ack_i(ack), .wdata_done_i(wdone), .rdata_done_i(rdone),
    .wr_o(wr_o), .rd_o(rd_o),
    .baddr_o(baddr_o), .raddr_o(raddr_o), .caddr_o(caddr_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] nxt(input logic [23:0] p, input logic [23:0] b,
                                      input logic [23:0] m);
    return b + ((p - b + 24'(BL)) % (m - b));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_kind = 0; m_addr = '0; m_wptr = '0; m_rptr = '0; m_last_rd = 1'b1;
  endtask

  task automatic model_step();
    bit          wp, rp;
    logic [23:0] nw, nr;
    wp = (wr_use >= BL) && !wr_load;
    rp = (rd_use < LIM) && !rd_load;
    nw = m_wptr; nr = m_rptr;
    if (m_phase == 0) begin
      if (wp && (!rp || m_last_rd)) begin
        m_phase = 1; m_kind = 0; m_addr = m_wptr; m_last_rd = 1'b0;
      end else if (rp) begin
        m_phase = 1; m_kind = 1; m_addr = m_rptr; m_last_rd = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (ack) m_phase = 2;
    end else begin
      if (m_kind == 0 && wdone) begin
        nw = nxt(m_wptr, wr_addr, wr_max_addr); m_phase = 0;
      end else if (m_kind == 1 && rdone) begin
        nr = nxt(m_rptr, rd_addr, rd_max_addr); m_phase = 0;
      end
    end
    if (wr_load) nw = wr_addr;
    if (rd_load) nr = rd_addr;
    m_wptr = nw; m_rptr = nr;
  endtask

  task automatic check_all();
    logic ew, er, eb;
    logic [23:0] a;
    ew = (m_phase == 1 && m_kind == 0);
    er = (m_phase == 1 && m_kind == 1);
    eb = (m_phase != 0);
    a  = m_addr;
    ncmp += 6;
    assert (wr_o === ew) else begin nfail++; $error("FAIL wr: got %b want %b t=%0t", wr_o, ew, $time); end
    assert (rd_o === er) else begin nfail++; $error("FAIL rd: got %b want %b t=%0t", rd_o, er, $time); end
    assert (busy_o === eb) else begin nfail++; $error("FAIL busy: got %b want %b t=%0t", busy_o, eb, $time); end
    assert (baddr_o === a[23:22]) else begin nfail++; $error("FAIL baddr: got %h want %h t=%0t", baddr_o, a[23:22], $time); end
    assert (raddr_o === a[21:9]) else begin nfail++; $error("FAIL raddr: got %h want %h t=%0t", raddr_o, a[21:9], $time); end
    assert (caddr_o === a[8:0]) else begin nfail++; $error("FAIL caddr: got %h want %h t=%0t", caddr_o, a[8:0], $time); end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Waits (bounded) for a command request; an expired bound is a failure.
  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && m_phase != 1; i++) tick();
    ncmp++;
    assert ((wr_o | rd_o) === 1'b1) else begin nfail++; $error("FAIL %s_timeout: got wr=%b rd=%b want a request", tag, wr_o, rd_o); end
  endtask

  task automatic ack_pulse();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  initial begin
    logic [8:0] held;
    rst = 1'b1; wr_load = 0; rd_load = 0; wr_use = 0; rd_use = 200;
    ack = 0; wdone = 0; rdone = 0;
    wr_addr = 24'h0; wr_max_addr = 24'h40;
    rd_addr = 24'h400200; rd_max_addr = 24'h400240;
    model_reset();
    #2;
    check_all();                               // reset state
    @(posedge clk); #1; rst = 1'b0;
    wr_load = 1; rd_load = 1; tick(); wr_load = 0; rd_load = 0; tick();

    // Both pending: grants alternate W, R, W, R starting with write.
    wr_use = 8; rd_use = 0;
    for (int g = 0; g < 4; g++) begin
      wait_req("alt");
      ncmp++;
      assert (wr_o === ((g % 2) == 0)) else begin nfail++; $error("FAIL alt%0d: got wr=%b want %b", g, wr_o, (g % 2) == 0); end
      if (g == 1) begin
        ncmp++;
        assert ({baddr_o, raddr_o, caddr_o} === {2'd1, 13'd1, 9'd0})
          else begin nfail++; $error("FAIL rd_first_addr: got %h/%h/%h want 1/1/0", baddr_o, raddr_o, caddr_o); end
      end
      ack_pulse(); tick();
      if (g % 2 == 0) wdone = 1'b1; else rdone = 1'b1;
      tick(); wdone = 0; rdone = 0;
    end

    // Write only: caddr 0, 8, ... 0x38 then wraps to 0.
    rd_use = 200; wr_load = 1; tick(); wr_load = 0;
    for (int i = 0; i < 9; i++) begin
      wait_req("wonly");
      ncmp++;
      assert (caddr_o === 9'((i * 8) % 64)) else begin nfail++; $error("FAIL wonly%0d: got %h want %h", i, caddr_o, (i * 8) % 64); end
      tick(); tick(); ack_pulse();
      repeat (9) tick();
      wdone = 1'b1; tick(); wdone = 1'b0;
    end

    // Acknowledge held off for 50 cycles.
    wait_req("hold");
    held = m_addr[8:0];
    for (int i = 0; i < 50; i++) begin
      tick();
      ncmp += 2;
      assert (wr_o === 1'b1) else begin nfail++; $error("FAIL hold_wr%0d: got %b want 1", i, wr_o); end
      assert (caddr_o === held) else begin nfail++; $error("FAIL hold_addr%0d: got %h want %h", i, caddr_o, held); end
    end
    ack_pulse();
    wr_load = 1'b1; tick();                      // load during the burst
    wdone = 1'b1; tick(); wdone = 1'b0;
    repeat (3) tick();                           // no write grant while loading
    wr_load = 1'b0; tick();

    // Nothing pending: read FIFO at limit, write FIFO short of a burst.
    wr_use = 7; rd_use = 128;
    repeat (3) tick();                           // drain any grant taken above
    if (m_phase == 1) ack_pulse();
    rdone = 1'b1; wdone = 1'b1; tick(); rdone = 0; wdone = 0; tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      ncmp++;
      assert (busy_o === 1'b0) else begin nfail++; $error("FAIL idle_busy%0d: got %b want 0", i, busy_o); end
    end

    // Randomized traffic, including stray acks/dones and loads.
    for (int i = 0; i < 1500; i++) begin
      wr_use  = 8'($urandom_range(0, 16));
      rd_use  = 8'($urandom_range(100, 160));
      ack     = ($urandom_range(0, 3) == 0);
      wdone   = ($urandom_range(0, 3) == 0);
      rdone   = ($urandom_range(0, 3) == 0);
      wr_load = ($urandom_range(0, 30) == 0);
      rd_load = ($urandom_range(0, 30) == 0);
      tick();
    end
    ack = 0; wdone = 0; rdone = 0; wr_load = 0; rd_load = 0;

    // Reset in the middle of a read burst.
    wr_use = 0; rd_use = 0;
    repeat (3) tick();
    if (m_phase == 2) begin rdone = 1'b1; wdone = 1'b1; tick(); rdone = 0; wdone = 0; end
    wait_req("rst");
    ack_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();                                 // immediate asynchronous effect
    rst = 1'b0; rd_use = 200;
    rdone = 1'b1; tick(); rdone = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
